// File: rtl/load_queue_pkg.sv
// Shared types for the Tomasulo load queue: ROB tags, CDB payload, queue entry and FSM state.
// LQ_DATA_WIDTH fixes the word width carried on the CDB and stored per entry.
package load_queue_pkg;

  localparam int unsigned LQ_DATA_WIDTH  = 16;
  localparam int unsigned ROB_ADDR_WIDTH = 3;

  typedef logic [ROB_ADDR_WIDTH-1:0] lc3b_rob_addr;

  typedef struct packed {
    logic                     valid;
    lc3b_rob_addr             tag;
    logic [LQ_DATA_WIDTH-1:0] data;
  } cdb_t;

  typedef struct packed {
    logic                     busy;
    logic                     ready;
    lc3b_rob_addr             Q;
    logic [LQ_DATA_WIDTH-1:0] V;
    logic [LQ_DATA_WIDTH-1:0] offset;
    lc3b_rob_addr             dest;
    logic                     byte_ld;
  } lq_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEM   = 2'd1,
    WB    = 2'd2,
    DRAIN = 2'd3
  } lq_state_t;

  // Zero-extended byte lane select for LDB results.
  function automatic logic [LQ_DATA_WIDTH-1:0] byte_lane(input logic [LQ_DATA_WIDTH-1:0] data,
                                                         input logic hi);
    logic [7:0] lane;
    lane = hi ? data[15:8] : data[7:0];
    return {{(LQ_DATA_WIDTH-8){1'b0}}, lane};
  endfunction

endpackage

// File: rtl/load_queue_entries.sv
// Load queue entry array: allocation at tail, CDB bypass/snoop, pop and flush clearing.
// LOAD_QUEUE_BYTE_EN controls whether the LDB flag is stored.
module load_queue_entries
  import load_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     alloc,
  input  logic [PTR_W-1:0]         tail,
  input  logic [PTR_W-1:0]         head,
  input  logic                     pop,
  input  lc3b_rob_addr             Q_in,
  input  logic                     Q_valid,
  input  logic [LQ_DATA_WIDTH-1:0] V,
  input  logic [LQ_DATA_WIDTH-1:0] offset_in,
  input  lc3b_rob_addr             dest_in,
  input  logic                     byte_in,
  input  cdb_t                     CDB_in,
  output lq_entry_t                head_entry_c
);

  lq_entry_t entries_q [DEPTH];
  lq_entry_t new_entry_c;
  logic      bypass_c;

`ifndef LOAD_QUEUE_BYTE_EN
  logic unused_byte_c;
  assign unused_byte_c = byte_in;
`endif

  // New entry; a same-cycle CDB match on the base tag makes it ready immediately.
  always_comb begin
    bypass_c            = Q_valid && CDB_in.valid && (CDB_in.tag == Q_in);
    new_entry_c         = '0;
    new_entry_c.busy    = 1'b1;
    new_entry_c.ready   = !Q_valid || bypass_c;
    new_entry_c.Q       = Q_in;
    new_entry_c.V       = bypass_c ? CDB_in.data : V;
    new_entry_c.offset  = offset_in;
    new_entry_c.dest    = dest_in;
`ifdef LOAD_QUEUE_BYTE_EN
    new_entry_c.byte_ld = byte_in;
`else
    new_entry_c.byte_ld = 1'b0;
`endif
  end

  assign head_entry_c = entries_q[head];

  // Pop and allocate never target the same slot: alloc needs !full, pop needs !empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (entries_q[i].busy && !entries_q[i].ready && CDB_in.valid &&
            (CDB_in.tag == entries_q[i].Q)) begin
          entries_q[i].V     <= CDB_in.data;
          entries_q[i].ready <= 1'b1;
        end
      end
      if (pop) begin
        entries_q[head].busy  <= 1'b0;
        entries_q[head].ready <= 1'b0;
      end
      if (alloc) begin
        entries_q[tail] <= new_entry_c;
      end
    end
  end

endmodule

// File: rtl/load_queue.sv
// Parametrised in-order load queue: head-only issue to the dcache, then CDB broadcast.
// Optional LOAD_QUEUE_BYTE_EN adds LDB byte extraction and word address alignment.
module load_queue
  import load_queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = LQ_DATA_WIDTH,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  WE,
  input  lc3b_rob_addr          Q_in,
  input  logic                  Q_valid,
  input  logic [DATA_WIDTH-1:0] V,
  input  logic [DATA_WIDTH-1:0] offset_in,
  input  lc3b_rob_addr          dest_in,
  input  logic                  byte_in,
  input  cdb_t                  CDB_in,
  output logic                  dmem_read,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  input  logic                  dmem_resp,
  output logic                  cdb_req,
  output lc3b_rob_addr          cdb_tag,
  output logic [DATA_WIDTH-1:0] cdb_data,
  input  logic                  cdb_grant,
  output logic                  empty,
  output logic                  full,
  output logic [CNT_W-1:0]      count
);

  lq_state_t             state_q, state_d;
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_d;
  lq_entry_t             head_entry_c;
  logic                  alloc_c, pop_c;
  logic [DATA_WIDTH-1:0] head_addr_c, result_c;
  logic                  read_d, req_d;
  logic [DATA_WIDTH-1:0] addr_d, data_d;
  lc3b_rob_addr          tag_d;

  logic unused_head_c;
  assign unused_head_c = ^{head_entry_c.Q, head_entry_c.byte_ld};

  assign alloc_c = WE && !full && !flush;

  load_queue_entries #(.DEPTH(DEPTH)) u_entries (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .alloc        (alloc_c),
    .tail         (tail_q),
    .head         (head_q),
    .pop          (pop_c),
    .Q_in         (Q_in),
    .Q_valid      (Q_valid),
    .V            (LQ_DATA_WIDTH'(V)),
    .offset_in    (LQ_DATA_WIDTH'(offset_in)),
    .dest_in      (dest_in),
    .byte_in      (byte_in),
    .CDB_in       (CDB_in),
    .head_entry_c (head_entry_c)
  );

  // Effective address and loaded result for the head entry.
  always_comb begin
    head_addr_c = DATA_WIDTH'(head_entry_c.V + head_entry_c.offset);
`ifdef LOAD_QUEUE_BYTE_EN
    if (!head_entry_c.byte_ld) begin
      head_addr_c[0] = 1'b0;
    end
    result_c = head_entry_c.byte_ld ?
               DATA_WIDTH'(byte_lane(LQ_DATA_WIDTH'(dmem_rdata), dmem_addr[0])) : dmem_rdata;
`else
    result_c = dmem_rdata;
`endif
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    addr_d  = dmem_addr;
    tag_d   = cdb_tag;
    data_d  = cdb_data;
    read_d  = 1'b0;
    req_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (head_entry_c.busy && head_entry_c.ready) begin
          state_d = MEM;
          addr_d  = head_addr_c;
        end
      end
      MEM: begin
        if (dmem_resp) begin
          state_d = WB;
          tag_d   = head_entry_c.dest;
          data_d  = result_c;
        end
      end
      WB: begin
        if (cdb_req && cdb_grant) begin
          state_d = IDLE;
          pop_c   = 1'b1;
        end
      end
      DRAIN: begin
        if (dmem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // An outstanding dcache read must still complete after a flush.
    if (flush) begin
      pop_c   = 1'b0;
      state_d = ((state_q == MEM || state_q == DRAIN) && !dmem_resp) ? DRAIN : IDLE;
    end
    read_d = (state_d == MEM) || (state_d == DRAIN);
    req_d  = (state_d == WB);
    if (!read_d) begin
      addr_d = '0;
    end
    if (!req_d) begin
      tag_d  = '0;
      data_d = '0;
    end
  end

  assign count_d = count + CNT_W'(alloc_c) - CNT_W'(pop_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      dmem_read <= 1'b0;
      dmem_addr <= '0;
      cdb_req   <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
    end else begin
      state_q   <= state_d;
      dmem_read <= read_d;
      dmem_addr <= addr_d;
      cdb_req   <= req_d;
      cdb_tag   <= tag_d;
      cdb_data  <= data_d;
      if (flush) begin
        head_q <= '0;
        tail_q <= '0;
        count  <= '0;
        empty  <= 1'b1;
        full   <= 1'b0;
      end else begin
        if (pop_c) begin
          head_q <= head_q + PTR_W'(1);
        end
        if (alloc_c) begin
          tail_q <= tail_q + PTR_W'(1);
        end
        count <= count_d;
        empty <= (count_d == '0);
        full  <= (count_d == CNT_W'(DEPTH));
      end
    end
  end

endmodule
